// File: rtl/clint_arbiter_pkg.sv
// Shared interface definitions for the data-bus peripherals and the CLINT arbiter.
// Holds the bus bundles, the arbiter state type and the CLINT register map.
package clint_arbiter_pkg;

   localparam int CLINT_ARB_TIMEOUT = 16;

   localparam logic [31:0] MTIMECMP_LOW_R  = 32'h0200_4000;
   localparam logic [31:0] MTIMECMP_HIGH_R = 32'h0200_4004;
   localparam logic [31:0] MTIME_LOW_R     = 32'h0200_BFF8;
   localparam logic [31:0] MTIME_HIGH_R    = 32'h0200_BFFC;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] w_data;
   } type_dbus2peri_s;

   typedef struct packed {
      logic        ack;
      logic [31:0] r_data;
   } type_peri2dbus_s;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } type_clint_arb_state_e;

endpackage

// File: rtl/clint_arbiter_rr_arb2.sv
// Two-way round-robin grant decision; purely combinational.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       rr_ptr,
   output logic       grant
);

   // A lone requester always wins; a tie is broken by the rotating pointer.
   always_comb begin
      grant = 1'b0;
      case (valid)
         2'b10:   grant = 1'b1;
         2'b11:   grant = rr_ptr;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/clint_arbiter.sv
// Shares the single CLINT port between the core data bus and the debug module,
// one transaction at a time, with a bounded wait for the CLINT response.
module clint_arbiter
   import clint_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = CLINT_ARB_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   input  type_dbus2peri_s dbus2arb0_i,
   input  logic            sel0_i,
   output type_peri2dbus_s arb2dbus0_o,
   input  type_dbus2peri_s dbus2arb1_i,
   input  logic            sel1_i,
   output type_peri2dbus_s arb2dbus1_o,
   output type_dbus2peri_s arb2clint_o,
   output logic            clint_sel_o,
   input  type_peri2dbus_s clint2arb_i,
   output logic            timeout_o
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   type_clint_arb_state_e state;
   type_clint_arb_state_e state_next;

   logic        rr_ptr;
   logic        winner;
   logic [7:0]  cnt;
   logic [31:0] rdata_q;
   logic        timeout_q;
   logic [1:0]  valid;
   logic        grant;
   logic        timeout_hit;

   assign valid       = {dbus2arb1_i.req & sel1_i, dbus2arb0_i.req & sel0_i};
   assign timeout_hit = (cnt == TIMEOUT_LAST) && !clint2arb_i.ack;

   rr_arb2 u_rr_arb2 (
      .valid  (valid),
      .rr_ptr (rr_ptr),
      .grant  (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (|valid) state_next = BUSY;
         BUSY:    if (clint2arb_i.ack || timeout_hit) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // An ack arriving on the last allowed cycle beats the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= 1'b0;
         winner    <= 1'b0;
         cnt       <= 8'd0;
         rdata_q   <= 32'd0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|valid) begin
                  winner    <= grant;
                  cnt       <= 8'd0;
                  timeout_q <= 1'b0;
               end
            end
            BUSY: begin
               if (clint2arb_i.ack) begin
                  rdata_q   <= clint2arb_i.r_data;
                  timeout_q <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q   <= 32'd0;
                  timeout_q <= 1'b1;
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP:    rr_ptr <= ~winner;
            default: ;
         endcase
      end
   end

   // Outputs are held at zero while reset is asserted so an abandoned
   // transaction can never leak an ack.
   always_comb begin
      arb2clint_o = '0;
      clint_sel_o = 1'b0;
      arb2dbus0_o = '0;
      arb2dbus1_o = '0;
      timeout_o   = 1'b0;
      if (!rst) begin
         case (state)
            BUSY: begin
               arb2clint_o = winner ? dbus2arb1_i : dbus2arb0_i;
               clint_sel_o = 1'b1;
            end
            RESP: begin
               if (winner) begin
                  arb2dbus1_o.ack    = 1'b1;
                  arb2dbus1_o.r_data = rdata_q;
               end else begin
                  arb2dbus0_o.ack    = 1'b1;
                  arb2dbus0_o.r_data = rdata_q;
               end
               timeout_o = timeout_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_clint_arbiter.sv
// Directed scenarios for clint_arbiter against a small behavioural CLINT whose
// ack arrives after a programmable number of BUSY cycles.
module tb_clint_arbiter;
   import clint_arbiter_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   type_dbus2peri_s dbus2arb0_i, dbus2arb1_i;
   logic            sel0_i, sel1_i;
   type_peri2dbus_s arb2dbus0_o, arb2dbus1_o;
   type_dbus2peri_s arb2clint_o;
   logic            clint_sel_o;
   type_peri2dbus_s clint2arb_i;
   logic            timeout_o;

   int tests_run = 0;
   int tests_failed = 0;

   int          busy_cnt = 0;
   int          ack_at = 0;
   logic [31:0] mtime = 32'h64;
   logic [63:0] mtimecmp = '0;

   clint_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .dbus2arb0_i (dbus2arb0_i),
      .sel0_i      (sel0_i),
      .arb2dbus0_o (arb2dbus0_o),
      .dbus2arb1_i (dbus2arb1_i),
      .sel1_i      (sel1_i),
      .arb2dbus1_o (arb2dbus1_o),
      .arb2clint_o (arb2clint_o),
      .clint_sel_o (clint_sel_o),
      .clint2arb_i (clint2arb_i),
      .timeout_o   (timeout_o)
   );

   always #5 clk = ~clk;

   // CLINT model: counts consecutive selected cycles, acks when the count hits ack_at.
   always @(posedge clk) begin
      busy_cnt <= clint_sel_o ? busy_cnt + 1 : 0;
      if (clint_sel_o && clint2arb_i.ack && arb2clint_o.we && arb2clint_o.addr == MTIMECMP_LOW_R)
         mtimecmp[31:0] <= arb2clint_o.w_data;
   end

   always_comb begin
      clint2arb_i = '0;
      if (clint_sel_o && busy_cnt == ack_at) begin
         clint2arb_i.ack = 1'b1;
         if (!arb2clint_o.we) begin
            case (arb2clint_o.addr)
               MTIME_LOW_R:    clint2arb_i.r_data = mtime;
               MTIMECMP_LOW_R: clint2arb_i.r_data = mtimecmp[31:0];
               default:        clint2arb_i.r_data = 32'd0;
            endcase
         end
      end
   end

   task automatic drive_req(input int n, input logic we, input logic [31:0] addr, input logic [31:0] data);
      type_dbus2peri_s b;
      b.req = 1'b1; b.we = we; b.be = 4'hF; b.addr = addr; b.w_data = data;
      if (n == 0) begin dbus2arb0_i = b; sel0_i = 1'b1; end
      else        begin dbus2arb1_i = b; sel1_i = 1'b1; end
   endtask

   task automatic idle_all();
      dbus2arb0_i = '0; dbus2arb1_i = '0; sel0_i = 1'b0; sel1_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_all();
      repeat (2) @(negedge clk);
      drive_req(0, 1'b0, MTIME_LOW_R, 32'd0);
      @(negedge clk);
      tests_run++;
      if (clint_sel_o !== 1'b0 || arb2clint_o !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_clint: sel=%b bundle=%h expected 0", clint_sel_o, arb2clint_o);
      end
      tests_run++;
      if (arb2dbus0_o !== '0 || arb2dbus1_o !== '0 || timeout_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_resp: r0=%h r1=%h to=%b expected 0", arb2dbus0_o, arb2dbus1_o, timeout_o);
      end
      idle_all();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      ack_at = 0;
      drive_req(0, 1'b0, MTIME_LOW_R, 32'd0);
      @(negedge clk);
      tests_run++;
      if (clint_sel_o !== 1'b1 || arb2clint_o.addr !== MTIME_LOW_R || arb2dbus0_o.ack !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL read_busy: sel=%b addr=%h ack0=%b expected 1/%h/0", clint_sel_o, arb2clint_o.addr, arb2dbus0_o.ack, MTIME_LOW_R);
      end
      @(negedge clk);
      tests_run++;
      if (arb2dbus0_o.ack !== 1'b1 || arb2dbus0_o.r_data !== 32'h64) begin
         tests_failed++;
         $display("[TB] FAIL read_ack: ack=%b data=%h expected 1/00000064", arb2dbus0_o.ack, arb2dbus0_o.r_data);
      end
      tests_run++;
      if (clint_sel_o !== 1'b0 || arb2dbus1_o !== '0) begin
         tests_failed++;
         $display("[TB] FAIL read_resp_side: sel=%b r1=%h expected 0/0", clint_sel_o, arb2dbus1_o);
      end
      idle_all();
      @(negedge clk);
      tests_run++;
      if (arb2dbus0_o.ack !== 1'b0 || clint_sel_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL read_after: ack=%b sel=%b expected 0/0", arb2dbus0_o.ack, clint_sel_o);
      end
   endtask

   task automatic test_write_req1();
      int seen_ack0 = 0;
      int ack1_cycle = -1;
      ack_at = 0;
      drive_req(1, 1'b1, MTIMECMP_LOW_R, 32'h1234);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (arb2dbus0_o.ack) seen_ack0++;
         if (arb2dbus1_o.ack && ack1_cycle < 0) begin
            ack1_cycle = i;
            idle_all();
         end
      end
      tests_run++;
      if (ack1_cycle != 2) begin
         tests_failed++;
         $display("[TB] FAIL write_ack_cycle: got %0d expected 2", ack1_cycle);
      end
      tests_run++;
      if (mtimecmp[31:0] !== 32'h1234) begin
         tests_failed++;
         $display("[TB] FAIL write_mtimecmp: got %h expected 00001234", mtimecmp[31:0]);
      end
      tests_run++;
      if (seen_ack0 != 0) begin
         tests_failed++;
         $display("[TB] FAIL write_no_ack0: got %0d acks expected 0", seen_ack0);
      end
   endtask

   task automatic test_round_robin();
      int who[4];
      logic [31:0] dat[4];
      int n = 0;
      int both = 0;
      int first = -1;
      int exp_who[4] = '{0, 1, 0, 1};
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ack_at = 0;
      drive_req(0, 1'b0, MTIME_LOW_R, 32'd0);
      drive_req(1, 1'b0, MTIMECMP_LOW_R, 32'd0);
      for (int c = 1; c <= 20 && n < 4; c++) begin
         @(negedge clk);
         if (arb2dbus0_o.ack && arb2dbus1_o.ack) both++;
         if (arb2dbus0_o.ack || arb2dbus1_o.ack) begin
            if (first < 0) first = c;
            who[n] = arb2dbus1_o.ack ? 1 : 0;
            dat[n] = arb2dbus1_o.ack ? arb2dbus1_o.r_data : arb2dbus0_o.r_data;
            n++;
         end
      end
      idle_all();
      @(negedge clk);
      tests_run++;
      if (n != 4 || first != 2 || both != 0) begin
         tests_failed++;
         $display("[TB] FAIL rr_count: acks=%0d first=%0d both=%0d expected 4/2/0", n, first, both);
      end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (k >= n || who[k] != exp_who[k] || dat[k] !== (exp_who[k] == 0 ? 32'h64 : 32'h1234)) begin
            tests_failed++;
            $display("[TB] FAIL rr_grant%0d: got req%0d data=%h expected req%0d", k, who[k], dat[k], exp_who[k]);
         end
      end
   endtask

   task automatic test_timeout();
      int busy = 0;
      int got = 0;
      logic [31:0] d = 32'hDEAD;
      logic to = 1'b0;
      ack_at = 1000;
      drive_req(0, 1'b0, MTIME_LOW_R, 32'd0);
      for (int c = 0; c < 40 && got == 0; c++) begin
         @(negedge clk);
         if (clint_sel_o) busy++;
         if (arb2dbus0_o.ack) begin
            got = 1; d = arb2dbus0_o.r_data; to = timeout_o;
         end
      end
      idle_all();
      tests_run++;
      if (got != 1 || busy != 16) begin
         tests_failed++;
         $display("[TB] FAIL timeout_len: ack=%0d busy=%0d expected 1/16", got, busy);
      end
      tests_run++;
      if (d !== 32'd0 || to !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_resp: data=%h to=%b expected 0/1", d, to);
      end
      @(negedge clk);
      tests_run++;
      if (timeout_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_pulse: got %b expected 0", timeout_o);
      end
      ack_at = 0;
   endtask

   task automatic test_ack_at_timeout();
      int busy = 0;
      int got = 0;
      logic [31:0] d = 32'hDEAD;
      logic to = 1'b1;
      ack_at = 15;
      drive_req(0, 1'b0, MTIME_LOW_R, 32'd0);
      for (int c = 0; c < 40 && got == 0; c++) begin
         @(negedge clk);
         if (clint_sel_o) busy++;
         if (arb2dbus0_o.ack) begin
            got = 1; d = arb2dbus0_o.r_data; to = timeout_o;
         end
      end
      idle_all();
      @(negedge clk);
      tests_run++;
      if (got != 1 || busy != 16 || d !== 32'h64 || to !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ack_wins: ack=%0d busy=%0d data=%h to=%b expected 1/16/00000064/0", got, busy, d, to);
      end
      ack_at = 0;
   endtask

   task automatic test_drop_in_busy();
      int busy = 0;
      int got = 0;
      logic [31:0] d = 32'hDEAD;
      ack_at = 3;
      drive_req(1, 1'b0, MTIMECMP_LOW_R, 32'd0);
      @(negedge clk);
      if (clint_sel_o) busy++;
      dbus2arb1_i.req = 1'b0;
      for (int c = 0; c < 20 && got == 0; c++) begin
         @(negedge clk);
         if (clint_sel_o) busy++;
         if (arb2dbus1_o.ack) begin
            got = 1; d = arb2dbus1_o.r_data;
         end
      end
      idle_all();
      @(negedge clk);
      tests_run++;
      if (got != 1 || busy != 4 || d !== 32'h1234) begin
         tests_failed++;
         $display("[TB] FAIL drop_in_busy: ack=%0d busy=%0d data=%h expected 1/4/00001234", got, busy, d);
      end
      ack_at = 0;
   endtask

   task automatic test_reset_mid_busy();
      ack_at = 0;
      drive_req(0, 1'b0, MTIME_LOW_R, 32'd0);
      repeat (2) @(negedge clk);
      idle_all();
      @(negedge clk);
      ack_at = 1000;
      drive_req(0, 1'b0, MTIME_LOW_R, 32'd0);
      repeat (2) @(negedge clk);
      tests_run++;
      if (clint_sel_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rst_busy_pre: sel=%b expected 1", clint_sel_o);
      end
      rst = 1'b1;
      idle_all();
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (arb2dbus0_o.ack !== 1'b0 || clint_sel_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_busy_noack: ack=%b sel=%b expected 0/0", arb2dbus0_o.ack, clint_sel_o);
      end
      @(negedge clk);
      tests_run++;
      if (arb2dbus0_o.ack !== 1'b0 || arb2dbus1_o.ack !== 1'b0 || clint_sel_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_busy_idle: ack0=%b ack1=%b sel=%b expected 0/0/0", arb2dbus0_o.ack, arb2dbus1_o.ack, clint_sel_o);
      end
      ack_at = 0;
      drive_req(0, 1'b0, MTIME_LOW_R, 32'd0);
      drive_req(1, 1'b0, MTIMECMP_LOW_R, 32'd0);
      repeat (2) @(negedge clk);
      tests_run++;
      if (arb2dbus0_o.ack !== 1'b1 || arb2dbus1_o.ack !== 1'b0 || arb2dbus0_o.r_data !== 32'h64) begin
         tests_failed++;
         $display("[TB] FAIL rst_rrptr: ack0=%b ack1=%b data=%h expected 1/0/00000064", arb2dbus0_o.ack, arb2dbus1_o.ack, arb2dbus0_o.r_data);
      end
      idle_all();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idle_all();
      test_reset();
      test_single_read();
      test_write_req1();
      test_round_robin();
      test_timeout();
      test_ack_at_timeout();
      test_drop_in_busy();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/clint_arbiter.md
CLINT_ARBITER -- requirements
Module: clint_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles in BUSY before forced completion; legal range 2..255.
REQ-002 SHALL have one clock and reset: synchronous, active-high.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port dbus2arb0_i  input  type_dbus2peri_s  requester 0 (core dbus) request bundle.
REQ-006 SHALL have port sel0_i  input  1  address-decoder CLINT select from requester 0.
REQ-007 SHALL have port arb2dbus0_o  output  type_peri2dbus_s  response (ack, r_data) to requester 0.
REQ-008 SHALL have ports dbus2arb1_i, sel1_i, arb2dbus1_o for requester 1 (debug module), with the same widths and meanings.
REQ-009 SHALL have port arb2clint_o  output  type_dbus2peri_s  forwarded request to the CLINT.
REQ-010 SHALL have port clint_sel_o  output  1  CLINT select.
REQ-011 SHALL have port clint2arb_i  input  type_peri2dbus_s  CLINT response.
REQ-012 SHALL have port timeout_o  output  1  one-cycle pulse on forced completion.

Function
REQ-013 SHALL treat requester n as valid when dbus2arbn_i.req && seln_i.
REQ-014 SHALL implement states IDLE, BUSY and RESP.
REQ-015 IDLE: if any requester is valid, SHALL latch the winner index, clear the timeout counter and move to BUSY next cycle; otherwise SHALL stay in IDLE.
REQ-016 Arbitration SHALL be 2-way round-robin: a lone valid requester wins; when both are valid, the requester named by rr_ptr wins.
REQ-017 BUSY: arb2clint_o SHALL equal the granted requester's live input bundle and clint_sel_o SHALL be 1.
REQ-018 BUSY: when clint2arb_i.ack=1, the arbiter SHALL capture clint2arb_i.r_data and move to RESP.
REQ-019 BUSY: the timeout counter SHALL increment each cycle without ack.
REQ-020 BUSY: when the counter equals TIMEOUT_CYCLES-1 with no ack, the arbiter SHALL capture r_data=0, pulse timeout_o in the RESP cycle and move to RESP.
REQ-021 If ack and timeout coincide, ack SHALL win and timeout_o SHALL stay 0.
REQ-022 RESP: arb2dbusW_o.ack=1 with the captured r_data for exactly one cycle, where W is the winner; clint_sel_o=0.
REQ-023 RESP: rr_ptr SHALL be set to ~W, and the next state SHALL be IDLE.
REQ-024 Outside BUSY, arb2clint_o and clint_sel_o SHALL be all zero.
REQ-025 A non-granted requester SHALL always see ack=0 and r_data=0.
REQ-026 Latency: request-to-ack = 1 (IDLE) + CLINT latency in BUSY (1 cycle for the current CLINT) + 1 (RESP), i.e. 3 cycles minimum.
REQ-027 Requesters SHALL hold req and data stable until ack and drop req the cycle after ack; a req still high in IDLE SHALL be treated as a new transaction.
REQ-028 A granted requester dropping req while in BUSY SHALL NOT abort the transaction; it completes normally.
REQ-029 The timeout counter SHALL be 8 bits wide and SHALL never wrap.

Reset
REQ-030 On reset, state SHALL be IDLE, rr_ptr=0, winner=0, counter=0 and captured data=0.
REQ-031 During reset, all outputs SHALL be 0.
REQ-032 Reset in BUSY or RESP SHALL abandon the transaction without emitting ack.

Structure
REQ-033 The state enum type_clint_arb_state_e and the CLINT_ARB_TIMEOUT default SHALL be placed in the shared interface defines package, alongside type_dbus2peri_s and type_peri2dbus_s.
REQ-034 The arbitration decision SHALL be a combinational sub-module rr_arb2 (inputs: valid[1:0], rr_ptr; output: grant index).
REQ-035 All other logic SHALL be in clint_arbiter.

Verification
REQ-036 Scenario: requester 0 reads MTIME_LOW_R (mtime=0x64) with requester 1 idle -> arb2dbus0_o.ack=1 with r_data=0x64 three cycles after req, then clint_sel_o=0.
REQ-037 Scenario: both requesters issue simultaneous reads after reset -> requester 0 acked first, requester 1 acked next; with both held asserted, grants alternate 0,1,0,1.
REQ-038 Scenario: requester 1 writes 0x1234 to MTIMECMP_LOW_R while requester 0 is idle -> mtimecmp[31:0]=0x1234 and arb2dbus0_o.ack never asserts.
REQ-039 Scenario: clint2arb_i.ack tied to 0 with TIMEOUT_CYCLES=16 -> ack with r_data=0 and timeout_o=1 in the same cycle, 17 cycles after entering BUSY.
REQ-040 Scenario: rst asserted for one cycle mid-BUSY -> no ack on the following cycle, state=IDLE, a new request is served with rr_ptr=0.
REQ-041 Scenario: ack and counter=TIMEOUT_CYCLES-1 coincide -> captured CLINT data is returned and timeout_o=0.
